// File: rtl/irom_loader_pkg.sv
// rtl/irom_loader_pkg.sv - shared types and constants for the instruction ROM loader
package irom_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } irom_ld_state_t;

    localparam int IROM_LD_HDR_BYTES = 4;

endpackage

// File: rtl/irom_loader_if.sv
// rtl/irom_loader_if.sv - byte stream input and ROM programming port of the loader
interface irom_loader_if #(
    parameter int XLEN = 32
);
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            rx_ready;
    logic            prog_en;
    logic [XLEN-1:0] prog_addr;
    logic [XLEN-1:0] prog_data;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, prog_en, prog_addr, prog_data
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, prog_en, prog_addr, prog_data
    );
endinterface

// File: rtl/irom_loader_byte_word_pack.sv
// rtl/irom_loader_byte_word_pack.sv - little-endian byte-to-word assembler shared by all frame fields
module byte_word_pack
    import irom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clr) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_data, shift_q[23:8]};
        end
    end

    // The fourth byte completes the word in the same cycle it arrives.
    assign word_valid = byte_valid & ~clr & (cnt_q == 2'(IROM_LD_HDR_BYTES - 1));
    assign word       = {byte_data, shift_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/irom_loader.sv
// rtl/irom_loader.sv - boot loader writing a checksummed byte frame into the instruction ROM
module irom_loader
    import irom_loader_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              ROM_SIZE  = 8192,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         core_ren,
    irom_loader_if.slave                 bus,
    output logic                         irom_ren,
    output logic                         core_hold,
    output logic                         load_busy,
    output logic                         load_done,
    output logic                         load_err,
    output logic [$clog2(ROM_SIZE/4):0]  words_loaded
);

    localparam int CAP  = ROM_SIZE / 4;
    localparam int WL_W = $clog2(CAP) + 1;

    irom_ld_state_t  state_q, state_d;
    logic [WL_W-1:0] count_q, count_d;
    logic [WL_W-1:0] wl_q, wl_d;
    logic [XLEN-1:0] csum_q, csum_d;
    logic            prog_en_q, prog_en_d;
    logic [XLEN-1:0] prog_addr_q, prog_addr_d;
    logic [XLEN-1:0] prog_data_q, prog_data_d;

    logic        pack_clr;
    logic        xfer;
    logic        word_valid;
    logic [31:0] word;

    assign load_busy = (state_q == HDR) | (state_q == DATA) | (state_q == CSUM);
    assign load_done = (state_q == DONE);
    assign load_err  = (state_q == ERR);
    assign core_hold = (state_q != DONE);
    assign irom_ren  = core_ren & ~core_hold;

    assign bus.rx_ready  = load_busy;
    assign bus.prog_en   = prog_en_q;
    assign bus.prog_addr = prog_addr_q;
    assign bus.prog_data = prog_data_q;
    assign words_loaded  = wl_q;

    assign xfer = bus.rx_valid & load_busy;

    byte_word_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .clr        (pack_clr),
        .byte_valid (xfer),
        .byte_data  (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wl_d        = wl_q;
        csum_d      = csum_q;
        prog_en_d   = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        pack_clr    = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d  = HDR;
                    wl_d     = '0;
                    csum_d   = '0;
                    pack_clr = 1'b1;
                end
            end
            HDR: begin
                if (word_valid) begin
                    // Full-width compare so huge counts cannot alias into range.
                    if (word > XLEN'(CAP)) begin
                        state_d = ERR;
                    end else if (word == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                        count_d = word[WL_W-1:0];
                    end
                end
            end
            DATA: begin
                if (word_valid) begin
                    prog_en_d   = 1'b1;
                    prog_data_d = word;
                    prog_addr_d = BASE_ADDR + (XLEN'(wl_q) << 2);
                    wl_d        = wl_q + WL_W'(1);
                    csum_d      = csum_q + word;
                    if (wl_q + WL_W'(1) == count_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (word_valid) begin
                    state_d = (word == csum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wl_q        <= '0;
            csum_q      <= '0;
            prog_en_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wl_q        <= wl_d;
            csum_q      <= csum_d;
            prog_en_q   <= prog_en_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
        end
    end

endmodule
